// File: rtl/writeback_regfile_if.sv
`default_nettype none
// ============================================================================
// Module   : writeback_regfile_if
// Brief    : Writeback latch, read ports and commit/forwarding bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface writeback_regfile_if;
    logic [31:0] in_ALU_result;
    logic [31:0] in_data_read;
    logic [4:0]  in_rd;
    logic [13:0] in_ctrl_signals;
    logic        stall;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] retire_count;

    modport master (
        output in_ALU_result, in_data_read, in_rd, in_ctrl_signals, stall,
        output rs1_addr, rs2_addr,
        input  rs1_data, rs2_data, wb_we, wb_rd, wb_data, retire_count
    );

    modport slave (
        input  in_ALU_result, in_data_read, in_rd, in_ctrl_signals, stall,
        input  rs1_addr, rs2_addr,
        output rs1_data, rs2_data, wb_we, wb_rd, wb_data, retire_count
    );
endinterface
`default_nettype wire

// File: rtl/writeback_regfile.sv
`default_nettype none
// ============================================================================
// Module   : writeback_regfile
// Brief    : Writeback select, 32x32 register file with write bypass,
//            commit export and retired-instruction counter.
// Revision : 1.0 - initial release
// ============================================================================
module writeback_regfile #(
    parameter int STATUS_REG = 30,
    parameter int BYPASS_EN  = 1
) (
    input  wire logic          clock,
    input  wire logic          reset,
    writeback_regfile_if.slave bus
);
    localparam logic [4:0] c_status_rd = STATUS_REG[4:0];

    logic [31:0] r_regs [0:31];
    logic [31:0] r_retire_count;

    logic        w_reg_write;
    logic        w_sel_data_read;
    logic        w_setx;
    logic        w_valid;
    logic        w_unused_ctrl;
    logic [4:0]  w_wb_rd;
    logic [31:0] w_wb_data;
    logic        w_wb_we;
    logic        w_retire;
    logic [31:0] w_rs1_reg;
    logic [31:0] w_rs2_reg;

    assign w_reg_write     = bus.in_ctrl_signals[0];
    assign w_sel_data_read = bus.in_ctrl_signals[1];
    assign w_setx          = bus.in_ctrl_signals[2];
    assign w_valid         = bus.in_ctrl_signals[3];
    assign w_unused_ctrl   = ^bus.in_ctrl_signals[13:4];

    // setx redirects to the status register and always takes the ALU value
    assign w_wb_rd   = w_setx ? c_status_rd : bus.in_rd;
    assign w_wb_data = (w_sel_data_read && !w_setx) ? bus.in_data_read
                                                     : bus.in_ALU_result;
    assign w_wb_we   = reset & w_reg_write & w_valid & ~bus.stall
                       & (w_wb_rd != 5'd0);
    assign w_retire  = w_valid & ~bus.stall;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= 32'd0;
            end
            r_retire_count <= 32'd0;
        end else begin
            if (w_wb_we) begin
                r_regs[w_wb_rd] <= w_wb_data;
            end
            if (w_retire) begin
                r_retire_count <= r_retire_count + 32'd1;
            end
        end
    end

    // Entry 0 is never written; the address check keeps r0 reading zero
    assign w_rs1_reg = (bus.rs1_addr == 5'd0) ? 32'd0 : r_regs[bus.rs1_addr];
    assign w_rs2_reg = (bus.rs2_addr == 5'd0) ? 32'd0 : r_regs[bus.rs2_addr];

    generate
        if (BYPASS_EN != 0) begin : g_bypass
            assign bus.rs1_data = (w_wb_we && bus.rs1_addr == w_wb_rd) ? w_wb_data
                                                                       : w_rs1_reg;
            assign bus.rs2_data = (w_wb_we && bus.rs2_addr == w_wb_rd) ? w_wb_data
                                                                       : w_rs2_reg;
        end else begin : g_no_bypass
            assign bus.rs1_data = w_rs1_reg;
            assign bus.rs2_data = w_rs2_reg;
        end
    endgenerate

    assign bus.wb_we        = w_wb_we;
    assign bus.wb_rd        = w_wb_rd;
    assign bus.wb_data      = w_wb_data;
    assign bus.retire_count = r_retire_count;
endmodule
`default_nettype wire
